// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B operand registers, B shifter, 4-op ALU, C register, flags.
// Optional N/V status flags are enabled with `define DATAPATH_SEQ_STATUS_EN.
module datapath_seq #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mov,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_shift,
  input  logic              cmd_azero,
  input  logic [RA_W-1:0]   cmd_dst,
  input  logic [RA_W-1:0]   cmd_srca,
  input  logic [RA_W-1:0]   cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              z_flag,
`ifdef DATAPATH_SEQ_STATUS_EN
  output logic              n_flag,
  output logic              v_flag,
`endif
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WB
  } state_t;

  function automatic logic signed [DATA_W-1:0] shift_b(
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               sh
  );
    case (sh)
      SH_LSL:  shift_b = b <<< 1;
      SH_LSR:  shift_b = $signed($unsigned(b) >> 1);
      SH_ASR:  shift_b = b >>> 1;
      SH_NONE: shift_b = b;
      default: shift_b = b;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] alu(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               op
  );
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_NOT:  alu = ~b;
      default: alu = '0;
    endcase
  endfunction

`ifdef DATAPATH_SEQ_STATUS_EN
  // Two's-complement overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
  function automatic logic signed_ovf(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] r,
    input logic [1:0]               op
  );
    case (op)
      OP_ADD:  signed_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  signed_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      default: signed_ovf = 1'b0;
    endcase
  endfunction
`endif

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_rf [NREG];
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_b;
  logic signed [DATA_W-1:0] r_c;
  logic                     r_z;
  logic                     r_done;
  logic                     r_mov;
  logic [1:0]               r_op;
  logic [1:0]               r_shift;
  logic                     r_azero;
  logic [RA_W-1:0]          r_dst;
  logic [RA_W-1:0]          r_srca;
  logic [RA_W-1:0]          r_srcb;
  logic [DATA_W-1:0]        r_imm;
`ifdef DATAPATH_SEQ_STATUS_EN
  logic                     r_n;
  logic                     r_v;
`endif

  logic signed [DATA_W-1:0] w_a_op;
  logic signed [DATA_W-1:0] w_b_sh;
  logic signed [DATA_W-1:0] w_alu;

  assign w_a_op = r_azero ? '0 : r_a;
  assign w_b_sh = shift_b(r_b, r_shift);
  assign w_alu  = alu(w_a_op, w_b_sh, r_op);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
      r_mov   <= 1'b0;
      r_op    <= OP_ADD;
      r_shift <= SH_NONE;
      r_azero <= 1'b0;
      r_dst   <= '0;
      r_srca  <= '0;
      r_srcb  <= '0;
      r_imm   <= '0;
`ifdef DATAPATH_SEQ_STATUS_EN
      r_n     <= 1'b0;
      r_v     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_mov   <= cmd_mov;
            r_op    <= cmd_op;
            r_shift <= cmd_shift;
            r_azero <= cmd_azero;
            r_dst   <= cmd_dst;
            r_srca  <= cmd_srca;
            r_srcb  <= cmd_srcb;
            r_imm   <= cmd_imm;
            r_state <= cmd_mov ? S_WB : S_LDA;
          end
        end
        // Operand reads happen after any earlier write-back, so back-to-back dependencies resolve.
        S_LDA: begin
          r_a     <= r_rf[r_srca];
          r_state <= S_LDB;
        end
        S_LDB: begin
          r_b     <= r_rf[r_srcb];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_c     <= w_alu;
          r_z     <= (w_alu == '0);
`ifdef DATAPATH_SEQ_STATUS_EN
          r_n     <= w_alu[DATA_W-1];
          r_v     <= signed_ovf(w_a_op, w_b_sh, w_alu, r_op);
`endif
          r_state <= S_WB;
        end
        S_WB: begin
          r_rf[r_dst] <= r_mov ? $signed(r_imm) : r_c;
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE) && reset_n;
  assign done      = r_done;
  assign result    = r_c;
  assign z_flag    = r_z;
  assign dbg_data  = r_rf[dbg_addr];
`ifdef DATAPATH_SEQ_STATUS_EN
  assign n_flag    = r_n;
  assign v_flag    = r_v;
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed scenarios plus random commands against an arithmetic reference model.
// Checks n_flag/v_flag only when DATAPATH_SEQ_STATUS_EN is defined.
module tb_datapath_seq;

  localparam int W    = 16;
  localparam int NR   = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mov;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_shift;
  logic          cmd_azero;
  logic [2:0]    cmd_dst;
  logic [2:0]    cmd_srca;
  logic [2:0]    cmd_srcb;
  logic [W-1:0]  cmd_imm;
  logic          done;
  logic [W-1:0]  result;
  logic          z_flag;
`ifdef DATAPATH_SEQ_STATUS_EN
  logic          n_flag;
  logic          v_flag;
`endif
  logic [2:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  int tests = 0;
  int fails = 0;

  int unsigned ref_rf [NR];
  int unsigned ref_c;
  int unsigned ref_z, ref_n, ref_v;

  always #5 clk = ~clk;

  datapath_seq #(.DATA_W(W), .NREG(NR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mov   (cmd_mov),
    .cmd_op    (cmd_op),
    .cmd_shift (cmd_shift),
    .cmd_azero (cmd_azero),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .result    (result),
    .z_flag    (z_flag),
`ifdef DATAPATH_SEQ_STATUS_EN
    .n_flag    (n_flag),
    .v_flag    (v_flag),
`endif
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_shift(input int unsigned b, input int unsigned sh);
    case (sh)
      1:       return (b * 2) % MOD;
      2:       return b / 2;
      3:       return b / 2 + ((b >= HALF) ? HALF : 0);
      default: return b;
    endcase
  endfunction

  function automatic int to_signed(input int unsigned x);
    return (x >= HALF) ? int'(x) - MOD : int'(x);
  endfunction

  // Reference: apply one whole command to the architectural state.
  task automatic model_cmd(input logic mov, input logic [1:0] op, input logic [1:0] sh, input logic az,
                           input int dst, input int sa, input int sb, input int unsigned imm);
    int unsigned a, b, r;
    int s;
    if (mov) begin
      ref_rf[dst] = imm;
    end else begin
      a = az ? 0 : ref_rf[sa];
      b = m_shift(ref_rf[sb], sh);
      case (op)
        2'd0:    r = (a + b) % MOD;
        2'd1:    r = (a + MOD - b) % MOD;
        2'd2:    r = a & b;
        default: r = (MOD - 1) - b;
      endcase
      ref_v = 0;
      if (op == 2'd0 || op == 2'd1) begin
        s = (op == 2'd0) ? to_signed(a) + to_signed(b) : to_signed(a) - to_signed(b);
        ref_v = (s > HALF - 1 || s < -HALF) ? 1 : 0;
      end
      ref_c = r;
      ref_z = (r == 0) ? 1 : 0;
      ref_n = (r >= HALF) ? 1 : 0;
      ref_rf[dst] = r;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_rf[i] = 0;
    ref_c = 0; ref_z = 0; ref_n = 0; ref_v = 0;
  endtask

  task automatic read_reg(input int idx, output logic [W-1:0] val);
    dbg_addr = idx[2:0];
    #1;
    val = dbg_data;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_res"}, result, ref_c);
    check({tag, "_z"}, z_flag, ref_z);
`ifdef DATAPATH_SEQ_STATUS_EN
    check({tag, "_n"}, n_flag, ref_n);
    check({tag, "_v"}, v_flag, ref_v);
`endif
  endtask

  task automatic run_cmd(input string tag, input logic mov, input logic [1:0] op, input logic [1:0] sh,
                         input logic az, input int dst, input int sa, input int sb, input int unsigned imm);
    int n, lat;
    logic [W-1:0] rd;
    @(negedge clk);
    cmd_mov = mov; cmd_op = op; cmd_shift = sh; cmd_azero = az;
    cmd_dst = dst[2:0]; cmd_srca = sa[2:0]; cmd_srcb = sb[2:0]; cmd_imm = imm[W-1:0];
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    model_cmd(mov, op, sh, az, dst, sa, sb, imm);
    check({tag, "_lat"}, lat, mov ? 1 : 4);
    check({tag, "_rdy_done"}, cmd_ready, 1);
    check_flags(tag);
    read_reg(dst, rd);
    check({tag, "_rf"}, rd, ref_rf[dst]);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] rd;
    int bad;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_mov = 1'b0; cmd_op = 2'd0; cmd_shift = 2'd0;
    cmd_azero = 1'b0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_ready_low", cmd_ready, 0);
    check_flags("rst");
    reset_n = 1'b1;
    #1;
    check("rst_ready", cmd_ready, 1);
    for (int i = 0; i < NR; i++) begin
      read_reg(i, rd);
      check($sformatf("rst_r%0d", i), rd, 0);
    end

    // Scenario 1: R2 = R1 + (R0 << 1)
    run_cmd("t1_mov0", 1, 0, 0, 0, 0, 0, 0, 7);
    run_cmd("t1_mov1", 1, 0, 0, 0, 1, 0, 0, 2);
    run_cmd("t1_add", 0, 0, 1, 0, 2, 1, 0, 0);
    read_reg(2, rd);
    check("t1_r2_const", rd, 16);
    check("t1_res_const", result, 16);

    // Reset while the ADD into R2 is in EXEC
    @(negedge clk);
    cmd_mov = 0; cmd_op = 0; cmd_shift = 1; cmd_azero = 0; cmd_dst = 2; cmd_srca = 1; cmd_srcb = 0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("rs_done", done, 0);
    check_flags("rs");
    bad = 0;
    for (int i = 0; i < NR; i++) begin
      read_reg(i, rd);
      if (rd !== '0) bad++;
    end
    check("rs_rf_zero", bad, 0);
    reset_n = 1'b1;
    #1;
    check("rs_ready", cmd_ready, 1);
    bad = 0;
    repeat (6) begin @(negedge clk); if (done !== 1'b0) bad++; end
    check("rs_no_done", bad, 0);

    // Scenario 2: SUB with logical right shift, then AND
    run_cmd("t2_mov0", 1, 0, 0, 0, 0, 0, 0, 13);
    run_cmd("t2_mov1", 1, 0, 0, 0, 1, 0, 0, 7);
    run_cmd("t2_sub", 0, 1, 2, 0, 2, 0, 1, 0);
    check("t2_sub_const", result, 10);
    run_cmd("t2_mov3", 1, 0, 0, 0, 3, 0, 0, 16'h00F8);
    run_cmd("t2_mov4", 1, 0, 0, 0, 4, 0, 0, 16'h001F);
    run_cmd("t2_and", 0, 2, 0, 0, 0, 3, 4, 0);
    check("t2_and_const", result, 16'h0018);

    // Scenario 3: NOT of arithmetic-shifted B, then zero result
    run_cmd("t3_mov5", 1, 0, 0, 0, 5, 0, 0, 16'h8F00);
    run_cmd("t3_not", 0, 3, 3, 0, 7, 2, 5, 0);
    check("t3_not_const", result, 16'h387F);
    run_cmd("t3_sub0", 0, 1, 0, 0, 6, 0, 0, 0);
    check("t3_z_const", z_flag, 1);

    // Back-to-back: MOV then ADD with cmd_valid held
    @(negedge clk);
    cmd_mov = 1; cmd_dst = 1; cmd_imm = 16'd5; cmd_valid = 1'b1;
    @(negedge clk);
    check("bb_busy", cmd_ready, 0);
    cmd_mov = 0; cmd_op = 0; cmd_shift = 0; cmd_azero = 0; cmd_dst = 3; cmd_srca = 1; cmd_srcb = 1;
    @(negedge clk);
    model_cmd(1, 0, 0, 0, 1, 0, 0, 5);
    check("bb_mov_done", done, 1);
    check("bb_mov_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_ready !== 1'b0) bad++;
    end
    check("bb_ready_low4", bad, 0);
    @(negedge clk);
    model_cmd(0, 0, 0, 0, 3, 1, 1, 0);
    check("bb_add_done", done, 1);
    check_flags("bb");
    check("bb_res_const", result, 10);

    // Signed overflow corner
    run_cmd("ov_mov0", 1, 0, 0, 0, 0, 0, 0, 16'h7FFF);
    run_cmd("ov_mov1", 1, 0, 0, 0, 1, 0, 0, 1);
    run_cmd("ov_add", 0, 0, 0, 0, 2, 0, 1, 0);
    check("ov_res_const", result, 16'h8000);

    // Random commands
    for (int i = 0; i < NR; i++)
      run_cmd($sformatf("init%0d", i), 1, 0, 0, 0, i, 0, 0, $urandom_range(0, MOD - 1));
    for (int i = 0; i < 40; i++)
      run_cmd($sformatf("rnd%0d", i), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
              $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
              $urandom_range(0, MOD - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
